// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, product is 2*WIDTH bits.
// Latency: start accepted at edge k -> done (and p) after edge k+WIDTH; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; a back-to-back start is accepted in the done cycle.
// Optional build macro SEQ_MUL_SIGNED_EN: two's-complement operands and a signed product.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     cap_a;
    logic [WIDTH-1:0]     cap_b;

`ifdef SEQ_MUL_SIGNED_EN
    logic                 neg;
    // Operands are stored as magnitudes; |-2^(W-1)| = 2^(W-1) still fits in WIDTH unsigned bits.
    assign cap_a  = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    assign cap_b  = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    assign result = neg ? (~acc_sum + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_sum;
`else
    assign cap_a  = a;
    assign cap_b  = b;
    assign result = acc_sum;
`endif

    // Partial product for the current iteration and the running sum it produces.
    assign last    = (cnt == CW'(WIDTH - 1));
    assign addend  = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign acc_sum = acc + addend;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, iterate in CALC, publish p on the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else if (accept) begin
            mcand  <= cap_a;
            mplier <= cap_b;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end else if (state == CALC) begin
            acc    <= acc_sum;
            mplier <= mplier >> 1;
            if (last) begin
                // Counter clears instead of wrapping so it is ready for the next operation.
                cnt <= '0;
                p   <= result;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
